// File: rtl/ysyx_23060208_pkg.sv
// Shared constants and types for the load/store unit.
package ysyx_23060208_pkg;

   // LSU control states
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2,
      StResp = 2'd3
   } lsu_state_e;

   // Bit positions inside the one-hot load vector {lbu,lhu,lw,lh,lb}
   localparam int unsigned LdLb  = 0;
   localparam int unsigned LdLh  = 1;
   localparam int unsigned LdLw  = 2;
   localparam int unsigned LdLhu = 3;
   localparam int unsigned LdLbu = 4;

   // Bit positions inside the one-hot store vector {sw,sh,sb}
   localparam int unsigned SbBit = 0;
   localparam int unsigned ShBit = 1;
   localparam int unsigned SwBit = 2;

   // Byte-strobe patterns before lane shifting
   localparam logic [3:0] MaskByte = 4'b0001;
   localparam logic [3:0] MaskHalf = 4'b0011;
   localparam logic [3:0] MaskWord = 4'b1111;

   // True when at most one bit is set (zero counts as valid here)
   function automatic logic at_most_one(input logic [7:0] v);
      return (v & (v - 8'd1)) == 8'd0;
   endfunction

endpackage

// File: rtl/ysyx_23060208_lsu_align.sv
// Combinational lane alignment: store strobes/data shift and load extraction/extension.
module ysyx_23060208_lsu_align
   import ysyx_23060208_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [4:0]            load_inst,
   input  logic [2:0]            store_inst,
   input  logic [1:0]            offset,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [3:0]            wmask,
   output logic [DATA_WIDTH-1:0] wdata_lane,
   output logic [DATA_WIDTH-1:0] rdata_ext
);

   logic [DATA_WIDTH-1:0] rdata_shift;

   // Byte strobes and store data moved into the addressed lanes
   always_comb begin
      wmask = 4'b0000;
      if (store_inst[SwBit]) begin
         wmask = MaskWord;
      end else if (store_inst[ShBit]) begin
         wmask = MaskHalf << offset;
      end else if (store_inst[SbBit]) begin
         wmask = MaskByte << offset;
      end
      wdata_lane = wdata << {offset, 3'b000};
   end

   // Bring the addressed bytes down to bit 0 and sign/zero extend
   always_comb begin
      rdata_shift = rdata >> {offset, 3'b000};
      rdata_ext   = rdata_shift;
      if (load_inst[LdLb]) begin
         rdata_ext = {{(DATA_WIDTH-8){rdata_shift[7]}}, rdata_shift[7:0]};
      end else if (load_inst[LdLh]) begin
         rdata_ext = {{(DATA_WIDTH-16){rdata_shift[15]}}, rdata_shift[15:0]};
      end else if (load_inst[LdLbu]) begin
         rdata_ext = {{(DATA_WIDTH-8){1'b0}}, rdata_shift[7:0]};
      end else if (load_inst[LdLhu]) begin
         rdata_ext = {{(DATA_WIDTH-16){1'b0}}, rdata_shift[15:0]};
      end
   end

endmodule

// File: rtl/ysyx_23060208_lsu.sv
// Load/store unit: one outstanding access, request/grant memory port, held writeback result.
module ysyx_23060208_lsu
   import ysyx_23060208_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REG_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   // EXU request
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4:0]            in_load_inst,
   input  logic [2:0]            in_store_inst,
   input  logic [DATA_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_wdata,
   input  logic [REG_WIDTH-1:0]  in_rd,
   // memory port
   output logic                  mem_req,
   input  logic                  mem_gnt,
   output logic                  mem_wen,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wmask,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   // writeback
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_wen,
   output logic [REG_WIDTH-1:0]  out_rd,
   output logic [DATA_WIDTH-1:0] out_rdata,
   output logic                  out_misalign
);

   lsu_state_e            state_q, state_d;
   logic [4:0]            load_q;
   logic [2:0]            store_q;
   logic [DATA_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [REG_WIDTH-1:0]  rd_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  misalign_q;
   logic                  wen_q;

   logic                  accept;
   logic                  ld_any, st_any, bad_vec, mis_in, no_op;
   logic [3:0]            wmask;
   logic [DATA_WIDTH-1:0] wdata_lane;
   logic [DATA_WIDTH-1:0] rdata_ext;

   // Classify the incoming request; only meaningful in the accept cycle
   always_comb begin
      ld_any  = |in_load_inst;
      st_any  = |in_store_inst;
      no_op   = !ld_any && !st_any;
      bad_vec = (ld_any && st_any) || !at_most_one(8'(in_load_inst)) ||
                !at_most_one(8'(in_store_inst));
      mis_in  = ((in_load_inst[LdLh] | in_load_inst[LdLhu] | in_store_inst[ShBit]) &
                 in_addr[0]) |
                ((in_load_inst[LdLw] | in_store_inst[SwBit]) & (in_addr[1:0] != 2'b00));
   end

   assign accept = in_valid && (state_q == StIdle);

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               state_d = (no_op || bad_vec || mis_in) ? StResp : StReq;
            end
         end
         StReq: begin
            if (mem_gnt) begin
               state_d = (|store_q) ? StResp : StWait;
            end
         end
         StWait: begin
            if (mem_rvalid) begin
               state_d = StResp;
            end
         end
         StResp: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register and captured request/result fields
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         load_q     <= '0;
         store_q    <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
         wen_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            load_q     <= in_load_inst;
            store_q    <= in_store_inst;
            addr_q     <= in_addr;
            wdata_q    <= in_wdata;
            rd_q       <= in_rd;
            rdata_q    <= '0;
            misalign_q <= !no_op && (bad_vec || mis_in);
            wen_q      <= 1'b0;
         end
         if ((state_q == StWait) && mem_rvalid) begin
            rdata_q <= rdata_ext;
            wen_q   <= (rd_q != '0);
         end
      end
   end

   ysyx_23060208_lsu_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .load_inst  (load_q),
      .store_inst (store_q),
      .offset     (addr_q[1:0]),
      .wdata      (wdata_q),
      .rdata      (mem_rdata),
      .wmask      (wmask),
      .wdata_lane (wdata_lane),
      .rdata_ext  (rdata_ext)
   );

   // Port outputs derived from state and captured fields
   always_comb begin
      in_ready     = (state_q == StIdle);
      mem_req      = (state_q == StReq);
      mem_wen      = |store_q;
      mem_addr     = {addr_q[DATA_WIDTH-1:2], 2'b00};
      mem_wdata    = wdata_lane;
      mem_wmask    = (mem_req && (|store_q)) ? wmask : 4'b0000;
      out_valid    = (state_q == StResp);
      out_wen      = out_valid && wen_q;
      out_misalign = out_valid && misalign_q;
      out_rd       = rd_q;
      out_rdata    = rdata_q;
   end

endmodule

// File: tb/tb_ysyx_23060208_lsu.sv
// Self-checking bench for the load/store unit: reference model plus per-cycle compare.
module tb_ysyx_23060208_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_load_inst = '0;
   logic [2:0]  in_store_inst = '0;
   logic [31:0] in_addr = '0;
   logic [31:0] in_wdata = '0;
   logic [4:0]  in_rd = '0;
   logic        mem_req;
   logic        mem_gnt = 1'b0;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_wen;
   logic [4:0]  out_rd;
   logic [31:0] out_rdata;
   logic        out_misalign;

   always #5 clk = ~clk;

   ysyx_23060208_lsu #(
      .DATA_WIDTH (32),
      .REG_WIDTH  (5)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_load_inst  (in_load_inst),
      .in_store_inst (in_store_inst),
      .in_addr       (in_addr),
      .in_wdata      (in_wdata),
      .in_rd         (in_rd),
      .mem_req       (mem_req),
      .mem_gnt       (mem_gnt),
      .mem_wen       (mem_wen),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_wmask     (mem_wmask),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_wen       (out_wen),
      .out_rd        (out_rd),
      .out_rdata     (out_rdata),
      .out_misalign  (out_misalign)
   );

   int total = 0;
   int bad = 0;

   // bench-side view of the handshake
   bit busy = 1'b0;
   int cyc = 0, acc_cyc = 0, lat = -1, req_cnt = 0, val_cnt = 0;
   logic [31:0] last_rdata, last_wdata;
   logic [3:0]  last_wmask;
   logic        last_wen, last_mis;

   // model expectations for the transaction in flight
   bit          e_mem, e_load, e_store, e_mis, e_wen;
   logic [31:0] e_addr, e_wdata, e_rdata;
   logic [3:0]  e_mask;
   logic [4:0]  e_rd;
   int          e_lat;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   // What the LSU must do for a request, derived from the instruction rules
   task automatic set_model(input logic [4:0] ld, input logic [2:0] st, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd,
                            input logic [31:0] rdata);
      int nl, ns, off, size, m;
      logic [31:0] v;
      nl = $countones(ld);
      ns = $countones(st);
      off = int'(addr % 4);
      e_mem = 0; e_load = 0; e_store = 0; e_mis = 0; e_wen = 0;
      e_addr = addr - 32'(off); e_wdata = '0; e_rdata = '0; e_mask = '0; e_rd = rd;
      e_lat = 1;
      size = 1;
      if (ld[1] || ld[3] || st[1]) size = 2;
      if (ld[2] || st[2]) size = 4;
      if (nl == 0 && ns == 0) begin
         e_mis = 0;
      end else if ((nl > 0 && ns > 0) || nl > 1 || ns > 1) begin
         e_mis = 1;
      end else if (off % size != 0) begin
         e_mis = 1;
      end else begin
         e_mem = 1;
         if (ns == 1) begin
            e_store = 1;
            m = ((1 << size) - 1) << off;
            e_mask = m[3:0];
            e_wdata = wdata << (8 * off);
            e_lat = 2;
         end else begin
            e_load = 1;
            v = rdata >> (8 * off);
            if (size == 1) v = v & 32'hFF;
            if (size == 2) v = v & 32'hFFFF;
            if (ld[0] && v >= 32'd128) v = v | 32'hFFFFFF00;
            if (ld[1] && v >= 32'd32768) v = v | 32'hFFFF0000;
            e_rdata = v;
            e_wen = (rd != 5'd0);
            e_lat = 3;
         end
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (rst) begin
         chk("in_ready", in_ready, !busy);
         if (in_valid && in_ready) acc_cyc = cyc;
         if (mem_req) begin
            req_cnt++;
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wen", mem_wen, e_store);
            if (e_store) begin
               chk("mem_wdata", mem_wdata, e_wdata);
               chk("mem_wmask", mem_wmask, e_mask);
            end
            last_wdata = mem_wdata;
            last_wmask = mem_wmask;
         end
         if (out_valid) begin
            if (val_cnt == 0) lat = cyc - acc_cyc;
            val_cnt++;
            chk("out_wen", out_wen, e_wen);
            chk("out_misalign", out_misalign, e_mis);
            chk("out_rd", out_rd, e_rd);
            if (e_load) chk("out_rdata", out_rdata, e_rdata);
            last_rdata = out_rdata;
            last_wen = out_wen;
            last_mis = out_misalign;
         end
      end
   end

   // One full transaction; entered and left at posedge+1
   task automatic run_txn(input logic [4:0] ld, input logic [2:0] st, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd,
                          input logic [31:0] rdata, input int gnt_dly, input int rdy_dly,
                          input bit noise);
      int n;
      set_model(ld, st, addr, wdata, rd, rdata);
      e_lat = e_mem ? e_lat + gnt_dly : e_lat;
      req_cnt = 0; val_cnt = 0; lat = -1;
      in_valid = 1; in_load_inst = ld; in_store_inst = st;
      in_addr = addr; in_wdata = wdata; in_rd = rd;
      @(posedge clk); #1;
      busy = 1;
      in_valid = 0;
      in_load_inst = 5'($urandom); in_store_inst = 3'($urandom);
      in_addr = $urandom; in_wdata = $urandom; in_rd = 5'($urandom);
      if (e_mem) begin
         for (int i = 0; i < gnt_dly; i++) begin
            mem_rvalid = noise; mem_rdata = $urandom;
            @(posedge clk); #1;
         end
         mem_rvalid = 0;
         mem_gnt = 1;
         @(posedge clk); #1;
         mem_gnt = 0;
         if (e_load) begin
            mem_rvalid = 1; mem_rdata = rdata;
            @(posedge clk); #1;
            mem_rvalid = 0; mem_rdata = $urandom;
         end
      end
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid) chk("out_valid_timeout", out_valid, 1'b1);
      for (int i = 0; i < rdy_dly; i++) begin
         mem_rvalid = noise; mem_rdata = $urandom;
         @(posedge clk); #1;
      end
      mem_rvalid = 0;
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      busy = 0;
      chk("req_cycles", req_cnt, e_mem ? gnt_dly + 1 : 0);
      chk("valid_cycles", val_cnt, rdy_dly + 1);
      chk("latency", lat, e_lat);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_mem_req"}, mem_req, 1'b0);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_out_wen"}, out_wen, 1'b0);
      chk({tag, "_out_misalign"}, out_misalign, 1'b0);
      chk({tag, "_out_rdata"}, out_rdata, 32'h0);
      chk({tag, "_out_rd"}, out_rd, 5'd0);
      chk({tag, "_mem_wmask"}, mem_wmask, 4'h0);
      chk({tag, "_in_ready"}, in_ready, 1'b1);
   endtask

   initial begin
      #2;
      chk_reset_outputs("por");
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;

      // lb sign extension from the top lane
      run_txn(5'b00001, 3'b000, 32'h8000_0003, 32'h0, 5'd5, 32'h80FF_0000, 0, 0, 0);
      chk("lb_lit_rdata", last_rdata, 32'hFFFF_FF80);
      chk("lb_lit_wen", last_wen, 1'b1);

      // sh into the upper half
      run_txn(5'b00000, 3'b010, 32'h8000_0002, 32'h1234_ABCD, 5'd6, 32'h0, 0, 0, 0);
      chk("sh_lit_wmask", last_wmask, 4'b1100);
      chk("sh_lit_wdata", last_wdata, 32'hABCD_0000);
      chk("sh_lit_wen", last_wen, 1'b0);

      // misaligned lw: no memory access, answer next cycle
      run_txn(5'b00100, 3'b000, 32'h8000_0006, 32'h0, 5'd3, 32'h0, 0, 0, 0);
      chk("lw_mis_lit", last_mis, 1'b1);
      chk("lw_mis_lat", lat, 1);
      chk("lw_mis_req", req_cnt, 0);

      // lhu zero extension
      run_txn(5'b01000, 3'b000, 32'h8000_0002, 32'h0, 5'd9, 32'hF00D_1234, 0, 0, 0);
      chk("lhu_lit_rdata", last_rdata, 32'h0000_F00D);

      // slow grant and slow consumer with stray rvalid pulses
      run_txn(5'b00100, 3'b000, 32'h8000_0010, 32'h0, 5'd10, 32'hCAFE_F00D, 4, 3, 1);
      chk("lw_slow_lit", last_rdata, 32'hCAFE_F00D);

      run_txn(5'b00000, 3'b100, 32'h8000_0020, 32'hDEAD_BEEF, 5'd1, 32'h0, 1, 0, 0);
      run_txn(5'b00000, 3'b001, 32'h8000_0021, 32'h0000_00A5, 5'd1, 32'h0, 0, 1, 1);
      chk("sb_lit_wmask", last_wmask, 4'b0010);
      run_txn(5'b00010, 3'b000, 32'h8000_0022, 32'h0, 5'd12, 32'h8001_7FFF, 0, 0, 0);
      chk("lh_lit_rdata", last_rdata, 32'hFFFF_8001);
      run_txn(5'b10000, 3'b000, 32'h8000_0001, 32'h0, 5'd13, 32'h0000_C500, 2, 0, 0);
      run_txn(5'b00100, 3'b000, 32'h8000_0040, 32'h0, 5'd0, 32'h1111_2222, 0, 0, 0);
      chk("lw_x0_wen", last_wen, 1'b0);
      run_txn(5'b00000, 3'b000, 32'h8000_0000, 32'h0, 5'd4, 32'h0, 0, 0, 0);
      chk("noop_mis", last_mis, 1'b0);
      run_txn(5'b00001, 3'b001, 32'h8000_0000, 32'h0, 5'd4, 32'h0, 0, 0, 0);
      run_txn(5'b00011, 3'b000, 32'h8000_0000, 32'h0, 5'd4, 32'h0, 0, 0, 0);
      run_txn(5'b00010, 3'b000, 32'h8000_0001, 32'h0, 5'd4, 32'h0, 0, 0, 0);
      run_txn(5'b00000, 3'b010, 32'h8000_0003, 32'h0, 5'd4, 32'h0, 0, 0, 0);
      run_txn(5'b00000, 3'b100, 32'h8000_0002, 32'h0, 5'd4, 32'h0, 0, 2, 0);

      // reset while waiting for read data; the late rvalid must be dropped
      set_model(5'b00100, 3'b000, 32'h8000_0010, 32'h0, 5'd7, 32'hDEAD_BEEF);
      req_cnt = 0; val_cnt = 0;
      in_valid = 1; in_load_inst = 5'b00100; in_store_inst = 3'b000;
      in_addr = 32'h8000_0010; in_rd = 5'd7;
      @(posedge clk); #1;
      busy = 1; in_valid = 0;
      mem_gnt = 1;
      @(posedge clk); #1;
      mem_gnt = 0;
      rst = 0; busy = 0;
      #1;
      chk_reset_outputs("wait_rst");
      @(posedge clk); #1;
      rst = 1;
      mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      mem_rvalid = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_no_valid", val_cnt, 0);
      chk("rst_no_req", req_cnt, 1);

      // normal operation after the reset
      run_txn(5'b00001, 3'b000, 32'h8000_0000, 32'h0, 5'd2, 32'h0000_007F, 0, 0, 0);
      chk("post_rst_lit", last_rdata, 32'h0000_007F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
